rs_syndrome_calc: RTL
=====================

Name: rs_syndrome_calc

Overview:
- Parametrised Reed-Solomon syndrome calculator over GF(2^8).
- First stage of the DVB-T RS(204,188,T=8) decoder chain; sits between the byte stream from the outer deinterleaver and the key-equation solver.
- Accepts one symbol per cycle with valid/start-of-frame framing, tolerates input gaps, and handles back-to-back frames with no bubble.
- Emits all 2T syndromes in parallel plus a nonzero flag once per frame.

Parameters:
- N, 204, codeword length in symbols; legal range 2T < N <= 255.
- T, 8, error-correction capability; 2T syndromes are produced.
- GF_POLY, 9'h11D, field primitive polynomial x^8+x^4+x^3+x^2+1.
- FCR, 0, first consecutive root; syndrome j evaluates r(alpha^(FCR+j)), with alpha = 0x02.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data carries a symbol this cycle.
- in_sof  in  1  qualified by in_valid; marks the first symbol of a frame (highest-degree coefficient).
- in_data  in  8  received symbol.
- synd_valid  out  1  one-cycle pulse; synd_out and synd_nonzero are valid.
- synd_out  out  16*T  syndromes; S_j occupies bits [8j+7:8j].
- synd_nonzero  out  1  OR-reduction of all S_j; 1 means errors are detected.
- frame_err  out  1  one-cycle pulse on a framing violation.
- busy  out  1  high while a frame is being accumulated.

Behaviour:
- Reset is synchronous and active-high on clock Clk.
  - All outputs go to 0: synd_valid=0, synd_out=0, synd_nonzero=0, frame_err=0, busy=0.
  - The FSM goes to IDLE, the symbol counter to 0, and the accumulators to 0.
- FSM states: IDLE and ACCUM.
- IDLE:
  - in_valid && in_sof: load S_j <= in_data for all j, cnt <= 1, go to ACCUM.
  - in_valid && !in_sof: drop the symbol and pulse frame_err.
- ACCUM:
  - in_valid && !in_sof: Horner step, S_j <= gfmul(S_j, alpha^(FCR+j)) XOR in_data; cnt <= cnt+1.
  - in_valid low: hold all state (gap); there is no timeout.
  - Last symbol accepted (cnt==N-1): in the same edge, update the accumulators, set result registers, go to IDLE.
  - in_valid && in_sof mid-frame (early SOF): abort the current frame, pulse frame_err, load the accumulators from in_data, cnt <= 1, stay in ACCUM. No synd_valid is produced for the aborted frame.
- Output timing:
  - synd_valid pulses exactly 1 cycle after the edge that accepted symbol N-1.
  - synd_out and synd_nonzero are registered and hold their value until the next synd_valid or Reset.
- Back-to-back frames:
  - An SOF in the cycle immediately after the last symbol is accepted from IDLE, so frames stream with zero gap.
  - The result registers are separate from the accumulators, so the new frame never corrupts the presented syndromes.
- busy = (state == ACCUM).
- frame_err is a one-cycle pulse per offending symbol.
- Arithmetic: GF(2^8) addition is XOR. Constant multiplication is a combinational XOR network derived from GF_POLY. There are no carries and widths stay 8 bits per syndrome.
- Counter width is ceil(log2(N)). The counter never wraps because it returns to IDLE at N-1.
- Reset asserted mid-frame discards the frame. No synd_valid is emitted, even if Reset coincides with the last symbol.

Decomposition:
- Package rs_pkg holds:
  - GF_POLY and the default N, T, FCR.
  - A function giving alpha^k as an 8-bit constant.
  - The FSM state encoding (IDLE=1'b0, ACCUM=1'b1).
- Sub-module gf_const_mul: combinational GF(2^8) multiply by a parameter constant, instantiated 2T times via generate.

Test Plan (N=204, T=8, FCR=0):
- All-zero frame of 204 symbols -> one synd_valid 1 cycle after the last symbol; all S_j=0x00; synd_nonzero=0; frame_err never asserts.
- Zero frame with symbol index 203 = 0x5A -> every S_j=0x5A; synd_nonzero=1.
- Zero frame with symbol index 202 = 0x01 -> S_0..S_7 = 01,02,04,08,10,20,40,80 and S_8..S_15 = 1D,3A,74,E8,CD,87,13,26.
- Two frames back-to-back with no gap plus random in_valid gaps of 1-5 cycles -> syndromes match a software model; exactly one synd_valid per frame; the first result is stable until the second synd_valid.
- SOF asserted at symbol 100, then a full clean frame -> frame_err pulses once; only one synd_valid, for the new frame, with all S_j=0.
- Reset asserted for 1 cycle at symbol 150, then a clean frame; also stray in_valid without SOF in IDLE -> no synd_valid for the interrupted frame; the stray symbol produces one frame_err pulse; the following frame decodes correctly.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared GF(2^8) constants, helper functions and FSM encoding for the RS syndrome calculator.
package rs_pkg;

  localparam logic [8:0] GF_POLY     = 9'h11D;
  localparam int         N_DEFAULT   = 204;
  localparam int         T_DEFAULT   = 8;
  localparam int         FCR_DEFAULT = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Multiply by alpha (x): shift left and fold bit 8 back in through the field polynomial.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a, input logic [8:0] poly);
    return {a[6:0], 1'b0} ^ (a[7] ? poly[7:0] : 8'h00);
  endfunction

  function automatic logic [7:0] alpha_pow(input int k, input logic [8:0] poly);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < (k % 255); i++) begin
      v = gf_xtime(v, poly);
    end
    return v;
  endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational GF(2^8) multiply by a constant; the constant's x^i multiples form the XOR network.
module gf_const_mul #(
  parameter logic [7:0] CONST = 8'h01,
  parameter logic [8:0] POLY  = rs_pkg::GF_POLY
) (
  input  logic [7:0] a,
  output logic [7:0] p
);
  import rs_pkg::*;

  logic [7:0] col [8];
  logic [7:0] pp  [8];

  assign col[0] = CONST;

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_col
      assign col[gi] = gf_xtime(col[gi-1], POLY);
    end
    for (gi = 0; gi < 8; gi++) begin : g_pp
      assign pp[gi] = a[gi] ? col[gi] : 8'h00;
    end
  endgenerate

  always_comb begin
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      p = p ^ pp[i];
    end
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator: Horner evaluation of 2T syndromes, one symbol per cycle.
module rs_syndrome_calc #(
  parameter int         N       = rs_pkg::N_DEFAULT,
  parameter int         T       = rs_pkg::T_DEFAULT,
  parameter logic [8:0] GF_POLY = rs_pkg::GF_POLY,
  parameter int         FCR     = rs_pkg::FCR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [7:0]        in_data,
  output logic              synd_valid,
  output logic [16*T-1:0]   synd_out,
  output logic              synd_nonzero,
  output logic              frame_err,
  output logic              busy
);
  import rs_pkg::*;

  localparam int              NS   = 2 * T;
  localparam int              CW   = $clog2(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [8*NS-1:0]   acc_reg;
  logic [8*NS-1:0]   prod;
  logic [8*NS-1:0]   horner_next;
  logic [8*NS-1:0]   load_next;
  logic [8*NS-1:0]   synd_reg;
  logic              synd_valid_reg;
  logic              synd_nonzero_reg;
  logic              frame_err_reg;
  logic              last_sym;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_synd
      gf_const_mul #(
        .CONST (alpha_pow(FCR + gi, GF_POLY)),
        .POLY  (GF_POLY)
      ) u_mul (
        .a (acc_reg[8*gi +: 8]),
        .p (prod[8*gi +: 8])
      );
      assign horner_next[8*gi +: 8] = prod[8*gi +: 8] ^ in_data;
      assign load_next[8*gi +: 8]   = in_data;
    end
  endgenerate

  assign last_sym = (cnt_reg == LAST);

  // Accumulators and result registers are separate so a new frame can start
  // while the previous frame's syndromes are still being presented.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      acc_reg          <= '0;
      synd_reg         <= '0;
      synd_valid_reg   <= 1'b0;
      synd_nonzero_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      synd_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (in_sof) begin
              acc_reg   <= load_next;
              cnt_reg   <= CW'(1);
              state_reg <= ACCUM;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (in_sof) begin
              // Early SOF: abandon the partial frame and restart on this symbol.
              frame_err_reg <= 1'b1;
              acc_reg       <= load_next;
              cnt_reg       <= CW'(1);
            end else begin
              acc_reg <= horner_next;
              if (last_sym) begin
                synd_reg         <= horner_next;
                synd_nonzero_reg <= |horner_next;
                synd_valid_reg   <= 1'b1;
                cnt_reg          <= '0;
                state_reg        <= IDLE;
              end else begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign synd_valid   = synd_valid_reg;
  assign synd_out     = synd_reg;
  assign synd_nonzero = synd_nonzero_reg;
  assign frame_err    = frame_err_reg;
  assign busy         = (state_reg == ACCUM);

endmodule
